// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB-first, one bit per clock.
// start/busy/done handshake; results are registered and held between done pulses.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic bit_s, bit_c, last_bit, load;

  always_comb begin
    bit_s    = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    bit_c    = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    load     = start && (state_q == IDLE || state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (load) begin
      // Subtract is A + ~B + ~borrow_in, so invert B and the incoming carry.
      op_a_d  = a;
      op_b_d  = b ^ {WIDTH{sub}};
      carry_d = c_in ^ sub;
      part_d  = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
      op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
      part_d  = {bit_s, part_q[WIDTH-1:1]};
      carry_d = bit_c;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        // On the MSB step carry_q is exactly the carry into the MSB.
        sum_d   = {bit_s, part_q[WIDTH-1:1]};
        c_out_d = bit_c;
        ovf_d   = carry_q ^ bit_c;
      end
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    sum   = sum_q;
    c_out = c_out_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=8 vectors and control corners, WIDTH=4 exhaustive sweep.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, c_in8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, c_out8, ovf8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, c_in4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, c_out4, ovf4;
  logic [3:0] sum4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  serial_adder_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  // Launch one WIDTH=8 operation and follow it to its done cycle (sampled on negedges).
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is,
                     output int nbusy, output logic saw_done);
    @(negedge clk);
    a8 = ia; b8 = ib; c_in8 = ic; sub8 = is; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nbusy = 0;
    while (busy8 && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
    saw_done = done8;
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic, input logic is,
                     output logic saw_done);
    int n;
    @(negedge clk);
    a4 = ia; b4 = ib; c_in4 = ic; sub4 = is; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (busy4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    saw_done = done4;
  endtask

  task automatic test_reset;
    int nb;
    logic sd;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy8, done8, sum8, c_out8, ovf8} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_state: busy/done/sum/c_out/ovf = %b/%b/%h/%b/%b, want 0/0/00/0/0",
               busy8, done8, sum8, c_out8, ovf8);
    end
    rst = 1'b0;
    op8(8'h7F, 8'h01, 1'b0, 1'b0, nb, sd);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy8, done8, sum8, c_out8, ovf8} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_async: busy/done/sum/c_out/ovf = %b/%b/%h/%b/%b, want 0/0/00/0/0",
               busy8, done8, sum8, c_out8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h01};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] vx [3] = '{{8'h10, 1'b0, 1'b0}, {8'h01, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}};
    int nb;
    logic sd;
    for (int i = 0; i < 3; i++) begin
      op8(va[i], vb[i], vc[i], 1'b0, nb, sd);
      n_tests++;
      if (nb !== 8) begin
        n_fail++;
        $display("FAIL add%0d_busy_cycles: got %0d, want 8", i, nb);
      end
      n_tests++;
      if (sd !== 1'b1) begin
        n_fail++;
        $display("FAIL add%0d_done: got %b, want 1", i, sd);
      end
      n_tests++;
      if ({sum8, c_out8, ovf8} !== vx[i]) begin
        n_fail++;
        $display("FAIL add%0d_result: sum/c/ovf = %h/%b/%b, want %h/%b/%b",
                 i, sum8, c_out8, ovf8, vx[i][9:2], vx[i][1], vx[i][0]);
      end
      @(negedge clk);
      n_tests++;
      if (done8 !== 1'b0) begin
        n_fail++;
        $display("FAIL add%0d_done_pulse_width: done still %b, want 0", i, done8);
      end
    end
  endtask

  task automatic test_sub;
    logic [7:0] va [2] = '{8'h05, 8'h80};
    logic [7:0] vb [2] = '{8'h07, 8'h01};
    logic [9:0] vx [2] = '{{8'hFE, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}};
    int nb;
    logic sd;
    for (int i = 0; i < 2; i++) begin
      op8(va[i], vb[i], 1'b0, 1'b1, nb, sd);
      n_tests++;
      if (sd !== 1'b1 || nb !== 8) begin
        n_fail++;
        $display("FAIL sub%0d_timing: done=%b busy_cycles=%0d, want 1 and 8", i, sd, nb);
      end
      n_tests++;
      if ({sum8, c_out8, ovf8} !== vx[i]) begin
        n_fail++;
        $display("FAIL sub%0d_result: sum/c/ovf = %h/%b/%b, want %h/%b/%b",
                 i, sum8, c_out8, ovf8, vx[i][9:2], vx[i][1], vx[i][0]);
      end
    end
  endtask

  task automatic test_start_during_run;
    int n;
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h03; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c_in8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
    n_tests++;
    if (sum8 !== 8'h7F) begin
      n_fail++;
      $display("FAIL hold_during_run: sum=%h, want 7f (previous result)", sum8);
    end
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if ({done8, sum8, c_out8, ovf8} !== {1'b1, 8'h23, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start_result: done/sum/c/ovf = %b/%h/%b/%b, want 1/23/0/0",
               done8, sum8, c_out8, ovf8);
    end
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_no_queue: busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (done8 !== 1'b1 || sum8 !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b sum=%h, want 1 30", done8, sum8);
    end
    a8 = 8'h40; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_tests++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, want 1 0", busy8, done8);
    end
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n !== 8 || done8 !== 1'b1 || sum8 !== 8'h42) begin
      n_fail++;
      $display("FAIL b2b_second: busy_cycles=%0d done=%b sum=%h, want 8 1 42", n, done8, sum8);
    end
  endtask

  task automatic test_abort;
    logic seen_done;
    int nb;
    logic sd;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0A; c_in8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = 1'b0;
      seen_done = seen_done | done8;
    end
    n_tests++;
    if (seen_done !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: seen_done=%b busy=%b, want 0 0", seen_done, busy8);
    end
    op8(8'h33, 8'h11, 1'b0, 1'b0, nb, sd);
    n_tests++;
    if (sd !== 1'b1 || {sum8, c_out8, ovf8} !== {8'h44, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_recover: done=%b sum/c/ovf = %h/%b/%b, want 1 44/0/0",
               sd, sum8, c_out8, ovf8);
    end
  endtask

  task automatic test_exhaustive4;
    int r, sr, sa, sb;
    logic [3:0] exp_s;
    logic exp_c, exp_v, sd, err;
    err = 1'b0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int k = 0; k < 4; k++) begin
          logic ic, is;
          ic = k[0];
          is = k[1];
          sa = (ia > 7) ? ia - 16 : ia;
          sb = (ib > 7) ? ib - 16 : ib;
          if (!is) begin
            r  = ia + ib + int'(ic);
            sr = sa + sb + int'(ic);
            exp_c = (r > 15);
          end else begin
            r  = ia - ib - int'(ic);
            sr = sa - sb - int'(ic);
            exp_c = (r >= 0);
          end
          exp_s = 4'(r);
          exp_v = (sr > 7) || (sr < -8);
          op4(ia[3:0], ib[3:0], ic, is, sd);
          n_tests++;
          if ({sd, sum4, c_out4, ovf4} !== {1'b1, exp_s, exp_c, exp_v}) begin
            n_fail++;
            err = 1'b1;
            $display("FAIL w4 a=%h b=%h cin=%b sub=%b: done/sum/c/ovf = %b/%h/%b/%b, want 1/%h/%b/%b",
                     ia[3:0], ib[3:0], ic, is, sd, sum4, c_out4, ovf4, exp_s, exp_c, exp_v);
          end
        end
      end
    end
    $display("[TB] WIDTH=4 exhaustive sweep error flag = %b", err);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_during_run();
    test_back_to_back();
    test_abort();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised bit-serial adder/subtractor. One full-adder cell plus a carry flip-flop processes an N-bit operand pair LSB-first, one bit per clock.
- A start/busy/done handshake controls each operation.
- Successor to the 1-bit structural full adder. Adds width generality, a subtract mode, signed-overflow detection and a sequential control FSM.
- Used as an arithmetic unit by lab datapaths and checked against a behavioural adder model in the bench.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- c_in  input  1  carry-in (borrow-in when sub=1); captured on start.
- sub  input  1  0 = A+B+c_in, 1 = A-B-c_in; captured on start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result registers updated.
- sum  output  WIDTH  result; held stable between done pulses.
- c_out  output  1  final carry out of the MSB.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, sum, c_out, ovf all 0; internal shift registers, carry and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load opA=a, opB=b XOR {WIDTH{sub}}, carry=c_in XOR sub, cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each edge: s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry).
  - s shifts into the MSB of the partial register; opA and opB shift right; cnt increments.
  - The carry into the MSB is captured when cnt==WIDTH-1.
  - After the WIDTH-th RUN edge: go to DONE. At that same edge, sum <= completed partial, c_out <= final carry, ovf <= carry_into_msb XOR final carry.
- DONE:
  - Lasts exactly one cycle; done=1.
  - start=1 in this cycle is accepted as in IDLE, giving back-to-back operation with no IDLE gap. Otherwise go to IDLE.
- busy is 1 exactly when state==RUN.
- Latency: start accepted at edge k means busy is high from after edge k until edge k+WIDTH. done is high in the cycle between edge k+WIDTH and edge k+WIDTH+1.
- start during RUN is ignored; no queueing.
- a, b, c_in and sub changes after acceptance have no effect on the operation in progress.
- sum, c_out and ovf never change except at the DONE-entry edge or at reset. Previous results stay visible during RUN.
- Subtract semantics:
  - c_out=1 means no borrow. Example: 5-7 gives c_out=0.
  - ovf is signed overflow of the effective A + ~B + 1 (or + ~B when c_in=1).
- Reset during RUN aborts the operation: done does not pulse, and outputs go to 0 immediately (asynchronously).
- Arithmetic is modulo 2^WIDTH; there are no undefined or X outputs after reset.

Test Plan:
- Reset, WIDTH=8: assert rst mid-cycle -> busy=0, done=0, sum=8'h00, c_out=0, ovf=0 immediately, without waiting for a clock edge.
- a=8'h0F, b=8'h01, c_in=0, sub=0, start for 1 cycle:
  - busy high for exactly 8 cycles, then a single done pulse.
  - Result: sum=8'h10, c_out=0, ovf=0.
- a=8'hFF, b=8'h01, c_in=1 -> sum=8'h01, c_out=1, ovf=0.
- a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, ovf=1.
- sub=1, a=8'h05, b=8'h07, c_in=0 -> sum=8'hFE, c_out=0, ovf=0. Also a=8'h80, b=8'h01 -> sum=8'h7F, c_out=1, ovf=1.
- Control corners:
  - start pulsed during RUN, with a and b changed, -> ignored; the first result is unchanged.
  - start held in the DONE cycle -> the next busy period begins with no IDLE cycle.
  - rst asserted at bit 4 -> no done pulse; a new start afterwards gives a correct result.
  - WIDTH=4 exhaustive check, all 2^10 combinations of a, b, c_in and sub, compared against a behavioural model on each done pulse; an error flag is displayed on any mismatch.
